// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, timeout default and pipeline register types
package mem_stage_pkg;
  localparam int DEFAULT_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} mem_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic        mem_to_reg;
    logic        reg_write;
  } hold_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        reg_write;
    logic        en;
  } wb_t;
endpackage

// File: rtl/mem_stage_dmem_if_fsm.sv
// dmem_if_fsm: data bus handshake sequencer with transaction timeout
module dmem_if_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bad,
  input  logic       is_write,
  input  logic       dmem_gnt,
  input  logic       dmem_rvalid,
  output mem_state_e state,
  output logic       done,
  output logic       mem_fault
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          timeout;
  always_comb begin
    done = (state == ADDR && dmem_gnt && is_write) || (state == RESP && dmem_rvalid);
    timeout = state != IDLE && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= bad || timeout;
      state <= start ? ADDR : (done || timeout) ? IDLE : (state == ADDR && dmem_gnt) ? RESP : state;
      cnt <= (state == IDLE || done || timeout) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with bus handshake, timeout and MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        combined_stall,
  input  logic        EX_MEM_enable_out,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemToReg,
  input  logic        EX_MEM_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [31:0] MEM_WB_ReadData,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_MemToReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_enable_out
);
  mem_state_e state;
  hold_t      hold;
  wb_t        wb_d, wb_q;
  logic       accept, mem_op, misaligned, start, bad, done;
  dmem_if_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bad(bad),
    .is_write(hold.we),
    .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .state(state),
    .done(done),
    .mem_fault(mem_fault)
  );
  always_comb begin
    accept = state == IDLE && EX_MEM_enable_out && !combined_stall;
    mem_op = EX_MEM_MemRead || EX_MEM_MemWrite;
    misaligned = |EX_MEM_ALUResult[1:0];
    start = accept && mem_op && !misaligned;
    bad = accept && mem_op && misaligned;
    wb_d = (accept && !mem_op) ?
             wb_t'{EX_MEM_PC, EX_MEM_ALUResult, 32'd0, EX_MEM_Rd, EX_MEM_MemToReg, EX_MEM_RegWrite, 1'b1} :
           done ?
             wb_t'{hold.pc, hold.addr, state == RESP ? dmem_rdata : 32'd0, hold.rd, hold.mem_to_reg, hold.reg_write, 1'b1} :
             '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold <= '0;
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
      if (start) hold <= hold_t'{EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd,
                                 EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite};
    end
  assign dmem_req = state == ADDR;
  assign dmem_we = dmem_req && hold.we;
  assign dmem_addr = hold.addr;
  assign dmem_wdata = hold.wdata;
  assign mem_stall = state != IDLE;
  assign MEM_WB_PC = wb_q.pc;
  assign MEM_WB_ALUResult = wb_q.alu;
  assign MEM_WB_ReadData = wb_q.rdata;
  assign MEM_WB_Rd = wb_q.rd;
  assign MEM_WB_MemToReg = wb_q.mem_to_reg;
  assign MEM_WB_RegWrite = wb_q.reg_write;
  assign MEM_WB_enable_out = wb_q.en;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        combined_stall, EX_MEM_enable_out;
  logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, mem_fault;
  logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_MemToReg, MEM_WB_RegWrite, MEM_WB_enable_out;
  int          errors = 0;
  int          checks = 0;
  logic        bad_hold;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .combined_stall(combined_stall),
    .EX_MEM_enable_out(EX_MEM_enable_out), .EX_MEM_PC(EX_MEM_PC),
    .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALUResult(MEM_WB_ALUResult), .MEM_WB_ReadData(MEM_WB_ReadData),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_MemToReg(MEM_WB_MemToReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_enable_out(MEM_WB_enable_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic en, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                    input logic [4:0] rd, input logic rd_op, input logic wr_op, input logic m2r, input logic rw);
    EX_MEM_enable_out = en; EX_MEM_PC = pc; EX_MEM_ALUResult = alu; EX_MEM_WriteData = wd;
    EX_MEM_Rd = rd; EX_MEM_MemRead = rd_op; EX_MEM_MemWrite = wr_op;
    EX_MEM_MemToReg = m2r; EX_MEM_RegWrite = rw;
  endtask

  initial begin
    reset_n = 1'b0; combined_stall = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    ex(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_en", MEM_WB_enable_out, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    // ALU op: one-cycle latency, no stall
    ex(1'b1, 32'h40, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alu_stall_pre", mem_stall, 0);
    @(negedge clk);
    chk("alu_en", MEM_WB_enable_out, 1);
    chk("alu_rd", MEM_WB_Rd, 5);
    chk("alu_res", MEM_WB_ALUResult, 32'h10);
    chk("alu_pc", MEM_WB_PC, 32'h40);
    chk("alu_rw", MEM_WB_RegWrite, 1);
    chk("alu_rdata", MEM_WB_ReadData, 0);
    chk("alu_stall", mem_stall, 0);
    combined_stall = 1'b1;
    @(negedge clk);
    chk("stall_bubble_en", MEM_WB_enable_out, 0);
    chk("stall_bubble_pc", MEM_WB_PC, 0);
    combined_stall = 1'b0;
    // load 0x100, gnt in second ADDR cycle, rvalid in third RESP cycle
    ex(1'b1, 32'h80, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall1", mem_stall, 1);
    chk("ld_en_addr", MEM_WB_enable_out, 0);
    ex(1'b1, 32'h84, 32'h999, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("ld_req2", dmem_req, 1);
    chk("ld_addr2", dmem_addr, 32'h100);
    chk("ld_ignore_ex", MEM_WB_enable_out, 0);
    chk("ld_stall2", mem_stall, 1);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("ld_req_drop", dmem_req, 0);
    chk("ld_stall3", mem_stall, 1);
    chk("ld_en_resp", MEM_WB_enable_out, 0);
    @(negedge clk);
    chk("ld_stall4", mem_stall, 1);
    @(negedge clk);
    chk("ld_stall5", mem_stall, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("ld_en", MEM_WB_enable_out, 1);
    chk("ld_rdata", MEM_WB_ReadData, 32'hDEAD_BEEF);
    chk("ld_alu", MEM_WB_ALUResult, 32'h100);
    chk("ld_rd", MEM_WB_Rd, 7);
    chk("ld_pc", MEM_WB_PC, 32'h80);
    chk("ld_m2r", MEM_WB_MemToReg, 1);
    chk("ld_stall_done", mem_stall, 0);
    @(negedge clk);
    chk("ld_single_pulse", MEM_WB_enable_out, 0);
    chk("ld_bubble_rdata", MEM_WB_ReadData, 0);
    // store 0x200 with MemRead also set (treated as write), gnt immediately
    ex(1'b1, 32'hC0, 32'h200, 32'h1234_5678, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'h1234_5678);
    ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("st_en", MEM_WB_enable_out, 1);
    chk("st_rw", MEM_WB_RegWrite, 0);
    chk("st_pc", MEM_WB_PC, 32'hC0);
    chk("st_req_low", dmem_req, 0);
    chk("st_stall", mem_stall, 0);
    // misaligned load
    ex(1'b1, 32'hD0, 32'h102, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mis_fault", mem_fault, 1);
    chk("mis_en", MEM_WB_enable_out, 0);
    chk("mis_rw", MEM_WB_RegWrite, 0);
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", mem_stall, 0);
    @(negedge clk);
    chk("mis_fault_pulse", mem_fault, 0);
    // timeout: gnt never arrives
    ex(1'b1, 32'hE0, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_req", dmem_req, 1);
    bad_hold = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1 || mem_fault !== 1'b0 || MEM_WB_enable_out !== 1'b0) bad_hold = 1'b1;
    end
    chk("to_hold", bad_hold, 0);
    @(negedge clk);
    chk("to_fault", mem_fault, 1);
    chk("to_req_low", dmem_req, 0);
    chk("to_stall", mem_stall, 0);
    chk("to_en", MEM_WB_enable_out, 0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("to_fault_pulse", mem_fault, 0);
    chk("to_late_gnt", dmem_req, 0);
    // reset in RESP abandons the read
    ex(1'b1, 32'hF0, 32'h400, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rr_in_resp", mem_stall, 1);
    chk("rr_addr_pre", dmem_addr, 32'h400);
    reset_n = 1'b0;
    #1;
    chk("rr_req", dmem_req, 0);
    chk("rr_stall", mem_stall, 0);
    chk("rr_addr", dmem_addr, 0);
    chk("rr_en", MEM_WB_enable_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rr_late_rvalid_en", MEM_WB_enable_out, 0);
    chk("rr_late_rvalid_data", MEM_WB_ReadData, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
